i2c_target_regs: RTL



---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_bus_monitor.sv | 48 ++++
 rtl/i2c_target_regs.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target register port and the write master.
// Optional read support is compiled in when I2C_TARGET_READ_EN is defined.
package i2c_pkg;

    localparam int unsigned BYTE_BITS = 8;
    localparam logic        I2C_ACK   = 1'b0;
    localparam logic        I2C_NACK  = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAckAddr,
        StReg,
        StAckReg,
        StWdata,
        StAckData,
        StIgnore
`ifdef I2C_TARGET_READ_EN
        ,
        StRdata,
        StAckMaster
`endif
    } i2cState_t;

    // Appends one received bit to a partially shifted byte, MSB first.
    function automatic logic [7:0] shiftIn(input logic [7:0] cur, input logic bitIn);
        return {cur[6:0], bitIn};
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronises raw SCL/SDA, detects SCL edges and START/STOP.
// Shared by the target regardless of I2C_TARGET_READ_EN.
module i2c_bus_monitor #(
    parameter int unsigned SYNC_STAGES = 2  // minimum 2
) (
    input  logic clock50M,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_sync
);

    logic [SYNC_STAGES-1:0] sclPipe;
    logic [SYNC_STAGES-1:0] sdaPipe;
    logic                   sclSync;
    logic                   sclPrev;
    logic                   sdaPrev;

    // Synchroniser chains plus one extra sample of each for edge detection.
    // Reset to the idle bus level so reset release creates no false edges.
    always_ff @(posedge clock50M or posedge reset) begin
        if (reset) begin
            sclPipe <= '1;
            sdaPipe <= '1;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPipe <= {sclPipe[SYNC_STAGES-2:0], scl_in};
            sdaPipe <= {sdaPipe[SYNC_STAGES-2:0], sda_in};
            sclPrev <= sclSync;
            sdaPrev <= sda_sync;
        end
    end

    assign sclSync  = sclPipe[SYNC_STAGES-1];
    assign sda_sync = sdaPipe[SYNC_STAGES-1];

    assign scl_rise  = sclSync & ~sclPrev;
    assign scl_fall  = ~sclSync & sclPrev;
    // SDA may only move while SCL is low; a move with SCL held high is a bus condition.
    assign start_det = sclSync & sclPrev & sdaPrev & ~sda_sync;
    assign stop_det  = sclSync & sclPrev & ~sdaPrev & sda_sync;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target register port: address match, register pointer, auto-incrementing
// byte writes into an external register file. Define I2C_TARGET_READ_EN to add
// the read form (0x73) that streams reg_rd_data back to the master.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h39,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock50M,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_pull_low,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    logic       sclRise;
    logic       sclFall;
    logic       startDet;
    logic       stopDet;
    logic       sdaSync;

    i2cState_t  state;
    logic [3:0] bitCount;
    logic [7:0] shifter;
    logic [7:0] rxByte;
    logic       lastBit;
    logic       ackPhase;   // 0: waiting for 8th fall, 1: holding ACK until 9th fall
    logic       wrPending;  // delays the strobe one cycle past the 8th sample
`ifdef I2C_TARGET_READ_EN
    logic       isRead;
`else
    logic       unusedRdData;
    assign unusedRdData = ^reg_rd_data;
`endif

    i2c_bus_monitor #(
        .SYNC_STAGES(SYNC_STAGES)
    ) busMonitor (
        .clock50M  (clock50M),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (sclRise),
        .scl_fall  (sclFall),
        .start_det (startDet),
        .stop_det  (stopDet),
        .sda_sync  (sdaSync)
    );

    assign rxByte  = shiftIn(shifter, sdaSync);
    assign lastBit = (bitCount == 4'(BYTE_BITS - 1));

    // Protocol FSM with registered bus and register-file outputs.
    always_ff @(posedge clock50M or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            bitCount     <= '0;
            shifter      <= '0;
            ackPhase     <= 1'b0;
            wrPending    <= 1'b0;
            sda_pull_low <= 1'b0;
            reg_wr_en    <= 1'b0;
            reg_addr     <= '0;
            reg_wr_data  <= '0;
            busy         <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            isRead       <= 1'b0;
`endif
        end else begin
            reg_wr_en <= wrPending;
            wrPending <= 1'b0;
            if (startDet) begin
                state        <= StAddr;
                bitCount     <= '0;
                ackPhase     <= 1'b0;
                sda_pull_low <= 1'b0;
                busy         <= 1'b1;
            end else if (stopDet) begin
                state        <= StIdle;
                bitCount     <= '0;
                ackPhase     <= 1'b0;
                sda_pull_low <= 1'b0;
                busy         <= 1'b0;
            end else begin
                unique case (state)
                    StIdle, StIgnore: begin
                    end
                    StAddr: begin
                        if (sclRise) begin
                            shifter <= rxByte;
                            if (lastBit) begin
                                bitCount <= '0;
                                ackPhase <= 1'b0;
                                if (rxByte[7:1] == SLAVE_ADDR && !rxByte[0]) begin
                                    state <= StAckAddr;
`ifdef I2C_TARGET_READ_EN
                                    isRead <= 1'b0;
                                end else if (rxByte[7:1] == SLAVE_ADDR) begin
                                    state  <= StAckAddr;
                                    isRead <= 1'b1;
`endif
                                end else begin
                                    state <= StIgnore;
                                end
                            end else begin
                                bitCount <= bitCount + 4'd1;
                            end
                        end
                    end
                    StAckAddr: begin
                        if (sclFall) begin
                            if (!ackPhase) begin
                                sda_pull_low <= ~I2C_ACK;
                                ackPhase     <= 1'b1;
                            end else begin
                                ackPhase <= 1'b0;
`ifdef I2C_TARGET_READ_EN
                                if (isRead) begin
                                    // First data bit goes out in place of the ACK release.
                                    sda_pull_low <= ~reg_rd_data[7];
                                    shifter      <= {reg_rd_data[6:0], 1'b0};
                                    bitCount     <= '0;
                                    state        <= StRdata;
                                end else
`endif
                                begin
                                    sda_pull_low <= 1'b0;
                                    state        <= StReg;
                                end
                            end
                        end
                    end
                    StReg: begin
                        if (sclRise) begin
                            shifter <= rxByte;
                            if (lastBit) begin
                                reg_addr <= rxByte;
                                bitCount <= '0;
                                ackPhase <= 1'b0;
                                state    <= StAckReg;
                            end else begin
                                bitCount <= bitCount + 4'd1;
                            end
                        end
                    end
                    StAckReg: begin
                        if (sclFall) begin
                            if (!ackPhase) begin
                                sda_pull_low <= ~I2C_ACK;
                                ackPhase     <= 1'b1;
                            end else begin
                                sda_pull_low <= 1'b0;
                                ackPhase     <= 1'b0;
                                state        <= StWdata;
                            end
                        end
                    end
                    StWdata: begin
                        if (sclRise) begin
                            shifter <= rxByte;
                            if (lastBit) begin
                                reg_wr_data <= rxByte;
                                wrPending   <= 1'b1;
                                bitCount    <= '0;
                                ackPhase    <= 1'b0;
                                state       <= StAckData;
                            end else begin
                                bitCount <= bitCount + 4'd1;
                            end
                        end
                    end
                    StAckData: begin
                        if (sclFall) begin
                            if (!ackPhase) begin
                                sda_pull_low <= ~I2C_ACK;
                                ackPhase     <= 1'b1;
                            end else begin
                                sda_pull_low <= 1'b0;
                                ackPhase     <= 1'b0;
                                reg_addr     <= reg_addr + 8'd1;
                                state        <= StWdata;
                            end
                        end
                    end
`ifdef I2C_TARGET_READ_EN
                    StRdata: begin
                        if (sclRise) begin
                            bitCount <= bitCount + 4'd1;
                        end else if (sclFall) begin
                            if (bitCount == 4'(BYTE_BITS)) begin
                                // Release SDA so the master can ACK/NACK.
                                sda_pull_low <= 1'b0;
                                bitCount     <= '0;
                                ackPhase     <= 1'b0;
                                state        <= StAckMaster;
                            end else begin
                                sda_pull_low <= ~shifter[7];
                                shifter      <= {shifter[6:0], 1'b0};
                            end
                        end
                    end
                    StAckMaster: begin
                        if (sclRise) begin
                            if (sdaSync == I2C_NACK) begin
                                state <= StIgnore;
                            end else begin
                                reg_addr <= reg_addr + 8'd1;
                                ackPhase <= 1'b1;
                            end
                        end else if (sclFall && ackPhase) begin
                            // reg_rd_data has settled for the new pointer by now.
                            ackPhase     <= 1'b0;
                            sda_pull_low <= ~reg_rd_data[7];
                            shifter      <= {reg_rd_data[6:0], 1'b0};
                            bitCount     <= '0;
                            state        <= StRdata;
                        end
                    end
`endif
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
